// File: rtl/aes_axil_ctrl_regs.sv
// aes_axil_ctrl_regs: AXI4-Lite register front-end for the AES core (key/din/ctrl/status/dout)
module aes_axil_ctrl_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [127:0]                      aes_key,
   output logic [127:0]                      aes_din,
   output logic                              aes_mode,
   output logic                              aes_start,
   input  logic                              aes_done,
   input  logic [127:0]                      aes_dout
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;
   logic aw_full, w_full, done, busy, commit, wr_err, ctrl_hit, start_ok, key_wr, din_wr, rd_err, unused_ok;
   logic [3:0] aw_idx, ar_idx, w_strb;
   logic [31:0] w_data, w_mask, w_word, rd_data;
   logic [127:0] dout;
   always_comb begin
      busy = state == RUN;
      S_AXI_AWREADY = !ARESET && S_AXI_AWVALID && !aw_full && !S_AXI_BVALID;
      S_AXI_WREADY = !ARESET && S_AXI_WVALID && !w_full && !S_AXI_BVALID;
      S_AXI_ARREADY = !ARESET && S_AXI_ARVALID && !S_AXI_RVALID;
      commit = aw_full && w_full && !S_AXI_BVALID;
      w_mask = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
      key_wr = aw_idx[3:2] == 2'd1;
      din_wr = aw_idx[3:2] == 2'd2;
      ctrl_hit = aw_idx == 4'd0 && w_strb[0];
      start_ok = ctrl_hit && w_data[0] && !busy;
      // key, din and mode are frozen while the core runs
      wr_err = aw_idx == 4'd2 || aw_idx == 4'd3 || aw_idx[3:2] == 2'd3 || (busy && (key_wr || din_wr || ctrl_hit));
      w_word = ((din_wr ? aes_din[{aw_idx[1:0], 5'd0} +: 32] : aes_key[{aw_idx[1:0], 5'd0} +: 32]) & ~w_mask) | (w_data & w_mask);
      ar_idx = S_AXI_ARADDR[5:2];
      rd_err = ar_idx == 4'd2 || ar_idx == 4'd3;
      rd_data = ar_idx == 4'd0 ? {30'd0, aes_mode, 1'b0} :
                ar_idx == 4'd1 ? {30'd0, done, busy} :
                ar_idx[3:2] == 2'd1 ? aes_key[{ar_idx[1:0], 5'd0} +: 32] :
                ar_idx[3:2] == 2'd2 ? aes_din[{ar_idx[1:0], 5'd0} +: 32] :
                ar_idx[3:2] == 2'd3 ? dout[{ar_idx[1:0], 5'd0} +: 32] : 32'd0;
      unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
   end
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state <= IDLE;
         aw_full <= 1'b0;
         w_full <= 1'b0;
         aw_idx <= '0;
         w_data <= '0;
         w_strb <= '0;
         done <= 1'b0;
         dout <= '0;
         aes_key <= '0;
         aes_din <= '0;
         aes_mode <= 1'b0;
         aes_start <= 1'b0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP <= 2'b00;
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA <= '0;
         S_AXI_RRESP <= 2'b00;
      end else begin
         aes_start <= 1'b0;
         if (S_AXI_AWREADY) begin
            aw_full <= 1'b1;
            aw_idx <= S_AXI_AWADDR[5:2];
         end
         if (S_AXI_WREADY) begin
            w_full <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         if (commit) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP <= wr_err ? 2'b10 : 2'b00;
            if (!wr_err && key_wr) aes_key[{aw_idx[1:0], 5'd0} +: 32] <= w_word;
            if (!wr_err && din_wr) aes_din[{aw_idx[1:0], 5'd0} +: 32] <= w_word;
            if (!wr_err && ctrl_hit) aes_mode <= w_data[1];
            if (aw_idx == 4'd1 && w_strb[0] && w_data[1]) done <= 1'b0;
            if (start_ok) begin
               state <= RUN;
               aes_start <= 1'b1;
               done <= 1'b0;
            end
         end else if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            aw_full <= 1'b0;
            w_full <= 1'b0;
         end
         // completion is placed after the clear so a same-cycle set wins
         if (busy && aes_done) begin
            state <= IDLE;
            dout <= aes_dout;
            done <= 1'b1;
         end
         if (S_AXI_ARREADY) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA <= rd_data;
            S_AXI_RRESP <= rd_err ? 2'b10 : 2'b00;
         end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
         end
      end
   end
endmodule
